// File: rtl/sobel_edge_detect_if.sv
// Pixel stream bundle: frame sync, line sync, pixel valid and pixel data.
interface sobel_edge_detect_if #(
  parameter int WIDTH = 8
);
  logic             vsync;
  logic             hsync;
  logic             de;
  logic [WIDTH-1:0] data;

  modport master (output vsync, hsync, de, data);
  modport slave  (input  vsync, hsync, de, data);
endinterface

// File: rtl/sobel_edge_detect.sv
// 3x3 Sobel |Gx|+|Gy| edge detector, 3-clk latency, syncs delay-matched.
// SOBEL_MAG_OUT_EN: export saturated magnitude on o_px.data instead of a binary map.
module sobel_edge_detect #(
  parameter int WIDTH      = 8,
  parameter int H_RES      = 170,
  parameter int V_RES      = 240,
  parameter int THRESH_DEF = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  sobel_edge_detect_if.slave   i_px,
  input  logic [WIDTH-1:0]     i_thresh,
  sobel_edge_detect_if.master  o_px,
  output logic                 o_edge
);

  localparam int CW = $clog2(H_RES);
  localparam int RW = $clog2(V_RES);
  localparam int GW = WIDTH + 3;
  localparam logic [CW-1:0] COL_MAX = CW'(H_RES - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(V_RES - 1);
  localparam logic [GW-1:0] SAT_MAX = GW'((1 << WIDTH) - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic             vs_q;
  logic [WIDTH-1:0] thr_q;

  logic [WIDTH-1:0] lb0 [H_RES];
  logic [WIDTH-1:0] lb1 [H_RES];

  logic [WIDTH-1:0] p11, p12, p13;
  logic [WIDTH-1:0] p21, p22, p23;
  logic [WIDTH-1:0] p31, p32, p33;
  logic             border;

  logic [WIDTH+1:0] gx_p, gx_n, gy_p, gy_n;
  logic signed [GW-1:0] gx, gy;
  logic             b1;

  logic [GW-1:0]    ax, ay, mag;
  logic [WIDTH-1:0] mag_sat;
  logic             hit;
  logic [WIDTH-1:0] data_n;
  logic [WIDTH-1:0] data_q;

  logic [2:0]       vs_d, hs_d, de_d;

  // Raster position; frame sync wins over a coincident pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col   <= '0;
      row   <= '0;
      vs_q  <= 1'b0;
      thr_q <= WIDTH'(THRESH_DEF);
    end else begin
      vs_q <= i_px.vsync;
      if (i_px.vsync && !vs_q)
        thr_q <= i_thresh;
      if (i_px.vsync) begin
        col <= '0;
        row <= '0;
      end else if (i_px.de) begin
        if (col == COL_MAX) begin
          col <= '0;
          if (row != ROW_MAX)
            row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_px.de) begin
      lb0[col] <= i_px.data;
      lb1[col] <= lb0[col];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p11 <= '0; p12 <= '0; p13 <= '0;
      p21 <= '0; p22 <= '0; p23 <= '0;
      p31 <= '0; p32 <= '0; p33 <= '0;
      border <= 1'b0;
    end else if (i_px.de) begin
      p11 <= p12; p12 <= p13; p13 <= lb1[col];
      p21 <= p22; p22 <= p23; p23 <= lb0[col];
      p31 <= p32; p32 <= p33; p33 <= i_px.data;
      border <= (row < RW'(2)) || (col < CW'(2));
    end
  end

  assign gx_p = {2'b00, p13} + {1'b0, p23, 1'b0} + {2'b00, p33};
  assign gx_n = {2'b00, p11} + {1'b0, p21, 1'b0} + {2'b00, p31};
  assign gy_p = {2'b00, p31} + {1'b0, p32, 1'b0} + {2'b00, p33};
  assign gy_n = {2'b00, p11} + {1'b0, p12, 1'b0} + {2'b00, p13};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gx <= '0;
      gy <= '0;
      b1 <= 1'b0;
    end else begin
      gx <= $signed({1'b0, gx_p}) - $signed({1'b0, gx_n});
      gy <= $signed({1'b0, gy_p}) - $signed({1'b0, gy_n});
      b1 <= border;
    end
  end

  always_comb begin
    ax      = gx[GW-1] ? GW'(-gx) : GW'(gx);
    ay      = gy[GW-1] ? GW'(-gy) : GW'(gy);
    mag     = ax + ay;
    mag_sat = (mag > SAT_MAX) ? {WIDTH{1'b1}} : mag[WIDTH-1:0];
    hit     = !b1 && (mag_sat >= thr_q);
`ifdef SOBEL_MAG_OUT_EN
    data_n  = b1 ? '0 : mag_sat;
`else
    data_n  = hit ? {WIDTH{1'b1}} : '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_edge <= 1'b0;
      data_q <= '0;
      vs_d   <= '0;
      hs_d   <= '0;
      de_d   <= '0;
    end else begin
      o_edge <= hit;
      data_q <= data_n;
      vs_d   <= {vs_d[1:0], i_px.vsync};
      hs_d   <= {hs_d[1:0], i_px.hsync};
      de_d   <= {de_d[1:0], i_px.de};
    end
  end

  assign o_px.vsync = vs_d[2];
  assign o_px.hsync = hs_d[2];
  assign o_px.de    = de_d[2];
  assign o_px.data  = data_q;

endmodule
